// File: rtl/regdisp_multi_fwd.sv
// ---------------------------------------------------------------------------
// regdisp_multi_fwd
//
// Register-native dispatcher: forwards one upstream transaction to one of
// FORWARD_NUM downstream slaves, selected by comparing the address tag
// (bits above REGION_AW) against each port's BASE_ADDR slice. The lowest
// matching port index wins. A three-state FSM (IDLE/WAIT/RESP) keeps exactly
// one transaction outstanding. Misses answer with an error response.
//
// Optional feature (compile-time macro REGDISP_TIMEOUT_EN):
//   adds a WAIT-state timeout counter and per-port stale bits. A timed-out
//   port is marked stale, its eventual late ack is swallowed (clearing the
//   bit), and requests to a stale port get an immediate error response.
//   Without the macro, WAIT lasts until the selected port acks or soft reset.
//
// Ports:
//   regdisp_disp_map_clk / regdisp_disp_map_rst_n : clock, async active-low reset
//   up_req_vld, up_addr, up_wr_en, up_rd_en, up_wr_data : upstream request
//   up_soft_rst                                      : upstream soft reset
//   up_ack_vld, up_err, up_rd_data                   : upstream response (registered)
//   ds_req_vld, ds_addr, ds_wr_en, ds_rd_en, ds_wr_data : per-port request (registered)
//   ds_soft_rst                                      : soft reset broadcast, 1-cycle delay
//   ds_ack_vld, ds_err, ds_rd_data                   : per-port response
// ---------------------------------------------------------------------------
module regdisp_multi_fwd #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FORWARD_NUM    = 4,
  parameter int unsigned REGION_AW      = 13,
  parameter logic [FORWARD_NUM*ADDR_WIDTH-1:0] BASE_ADDR = {(FORWARD_NUM*ADDR_WIDTH){1'b0}},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                              regdisp_disp_map_clk,
  input  logic                              regdisp_disp_map_rst_n,
  input  logic                              up_req_vld,
  input  logic [ADDR_WIDTH-1:0]             up_addr,
  input  logic                              up_wr_en,
  input  logic                              up_rd_en,
  input  logic [DATA_WIDTH-1:0]             up_wr_data,
  input  logic                              up_soft_rst,
  output logic                              up_ack_vld,
  output logic                              up_err,
  output logic [DATA_WIDTH-1:0]             up_rd_data,
  output logic [FORWARD_NUM-1:0]            ds_req_vld,
  output logic [FORWARD_NUM*ADDR_WIDTH-1:0] ds_addr,
  output logic [FORWARD_NUM-1:0]            ds_wr_en,
  output logic [FORWARD_NUM-1:0]            ds_rd_en,
  output logic [FORWARD_NUM*DATA_WIDTH-1:0] ds_wr_data,
  output logic [FORWARD_NUM-1:0]            ds_soft_rst,
  input  logic [FORWARD_NUM-1:0]            ds_ack_vld,
  input  logic [FORWARD_NUM-1:0]            ds_err,
  input  logic [FORWARD_NUM*DATA_WIDTH-1:0] ds_rd_data
);

  localparam int unsigned SEL_W = (FORWARD_NUM > 1) ? $clog2(FORWARD_NUM) : 1;
  localparam int unsigned TAG_W = ADDR_WIDTH - REGION_AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                        state_r;
  logic [SEL_W-1:0]              sel_r;
  logic                          up_ack_vld_r;
  logic                          up_err_r;
  logic [DATA_WIDTH-1:0]         up_rd_data_r;
  logic [FORWARD_NUM-1:0]        ds_req_vld_r;
  logic [FORWARD_NUM*ADDR_WIDTH-1:0] ds_addr_r;
  logic [FORWARD_NUM-1:0]        ds_wr_en_r;
  logic [FORWARD_NUM-1:0]        ds_rd_en_r;
  logic [FORWARD_NUM*DATA_WIDTH-1:0] ds_wr_data_r;
  logic [FORWARD_NUM-1:0]        ds_soft_rst_r;

  logic                          hit_s;
  logic [SEL_W-1:0]              hit_sel_s;
  logic [FORWARD_NUM-1:0]        stale_s;
  logic                          sel_ack_s;
  logic                          sel_err_s;
  logic [DATA_WIDTH-1:0]         sel_rd_data_s;
  logic [ADDR_WIDTH-1:0]         conv_addr_s;

  // One-hot vector with only bit 'sel' set.
  function automatic logic [FORWARD_NUM-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [FORWARD_NUM-1:0] vec;
    vec = {FORWARD_NUM{1'b0}};
    for (int i = 0; i < FORWARD_NUM; i++) begin
      vec[i] = (sel == SEL_W'(i));
    end
    return vec;
  endfunction

  // Address decode; iterating downwards lets the lowest matching index win.
  always_comb begin
    hit_s     = 1'b0;
    hit_sel_s = {SEL_W{1'b0}};
    for (int i = FORWARD_NUM - 1; i >= 0; i--) begin
      if (up_addr[ADDR_WIDTH-1:REGION_AW] ==
          BASE_ADDR[i*ADDR_WIDTH+REGION_AW +: TAG_W]) begin
        hit_s     = 1'b1;
        hit_sel_s = SEL_W'(i);
      end else begin
        hit_s     = hit_s;
        hit_sel_s = hit_sel_s;
      end
    end
  end

  // Region-relative address handed to the selected slave.
  assign conv_addr_s = {{TAG_W{1'b0}}, up_addr[REGION_AW-1:0]};

  // Response of the currently selected port; other ports' acks never reach the FSM.
  assign sel_ack_s     = ds_ack_vld[sel_r];
  assign sel_err_s     = ds_err[sel_r];
  assign sel_rd_data_s = ds_rd_data[sel_r*DATA_WIDTH +: DATA_WIDTH];

`ifdef REGDISP_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]       cnt_r;
  logic [FORWARD_NUM-1:0] stale_r;
  logic [FORWARD_NUM-1:0] stale_clr_s;

  // A late ack from a stale port is consumed here and retires its stale bit.
  assign stale_clr_s = ds_ack_vld & stale_r;
  assign stale_s     = stale_r;
`else
  assign stale_s     = {FORWARD_NUM{1'b0}};
`endif

  // Request/response FSM with all up_* and ds_* outputs registered.
  always_ff @(posedge regdisp_disp_map_clk or negedge regdisp_disp_map_rst_n) begin
    if (!regdisp_disp_map_rst_n) begin
      state_r       <= ST_IDLE;
      sel_r         <= {SEL_W{1'b0}};
      up_ack_vld_r  <= 1'b0;
      up_err_r      <= 1'b0;
      up_rd_data_r  <= {DATA_WIDTH{1'b0}};
      ds_req_vld_r  <= {FORWARD_NUM{1'b0}};
      ds_addr_r     <= {(FORWARD_NUM*ADDR_WIDTH){1'b0}};
      ds_wr_en_r    <= {FORWARD_NUM{1'b0}};
      ds_rd_en_r    <= {FORWARD_NUM{1'b0}};
      ds_wr_data_r  <= {(FORWARD_NUM*DATA_WIDTH){1'b0}};
      ds_soft_rst_r <= {FORWARD_NUM{1'b0}};
`ifdef REGDISP_TIMEOUT_EN
      cnt_r         <= {CNT_W{1'b0}};
      stale_r       <= {FORWARD_NUM{1'b0}};
`endif
    end else begin
      ds_soft_rst_r <= {FORWARD_NUM{up_soft_rst}};
      // Request strobe is a single-cycle pulse unless re-armed below.
      ds_req_vld_r  <= {FORWARD_NUM{1'b0}};
`ifdef REGDISP_TIMEOUT_EN
      stale_r       <= stale_r & ~stale_clr_s;
`endif
      case (state_r)
        ST_IDLE: begin
          up_ack_vld_r <= 1'b0;
          up_err_r     <= 1'b0;
          up_rd_data_r <= {DATA_WIDTH{1'b0}};
          if (up_req_vld) begin
            if (hit_s && !stale_s[hit_sel_s]) begin
              state_r      <= ST_WAIT;
              sel_r        <= hit_sel_s;
              ds_req_vld_r <= onehot(hit_sel_s);
              ds_wr_en_r   <= onehot(hit_sel_s) & {FORWARD_NUM{up_wr_en}};
              ds_rd_en_r   <= onehot(hit_sel_s) & {FORWARD_NUM{up_rd_en}};
              ds_addr_r    <= {(FORWARD_NUM*ADDR_WIDTH){1'b0}};
              ds_addr_r[hit_sel_s*ADDR_WIDTH +: ADDR_WIDTH]    <= conv_addr_s;
              ds_wr_data_r <= {(FORWARD_NUM*DATA_WIDTH){1'b0}};
              ds_wr_data_r[hit_sel_s*DATA_WIDTH +: DATA_WIDTH] <= up_wr_data;
`ifdef REGDISP_TIMEOUT_EN
              cnt_r        <= {CNT_W{1'b0}};
`endif
            end else begin
              // Decode miss or stale target: error answered without touching any slave.
              state_r      <= ST_RESP;
              up_ack_vld_r <= 1'b1;
              up_err_r     <= 1'b1;
              up_rd_data_r <= {DATA_WIDTH{1'b0}};
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_WAIT: begin
          if (up_soft_rst) begin
            // Abort silently: no upstream ack, slate wiped clean.
            state_r      <= ST_IDLE;
            ds_addr_r    <= {(FORWARD_NUM*ADDR_WIDTH){1'b0}};
            ds_wr_en_r   <= {FORWARD_NUM{1'b0}};
            ds_rd_en_r   <= {FORWARD_NUM{1'b0}};
            ds_wr_data_r <= {(FORWARD_NUM*DATA_WIDTH){1'b0}};
`ifdef REGDISP_TIMEOUT_EN
            cnt_r        <= {CNT_W{1'b0}};
            stale_r      <= {FORWARD_NUM{1'b0}};
`endif
          end else if (sel_ack_s) begin
            // An ack on the timeout cycle takes this branch and therefore wins.
            state_r      <= ST_RESP;
            up_ack_vld_r <= 1'b1;
            up_err_r     <= sel_err_s;
            up_rd_data_r <= sel_rd_data_s;
            ds_addr_r    <= {(FORWARD_NUM*ADDR_WIDTH){1'b0}};
            ds_wr_en_r   <= {FORWARD_NUM{1'b0}};
            ds_rd_en_r   <= {FORWARD_NUM{1'b0}};
            ds_wr_data_r <= {(FORWARD_NUM*DATA_WIDTH){1'b0}};
`ifdef REGDISP_TIMEOUT_EN
          end else if (cnt_r == CNT_LAST) begin
            state_r      <= ST_RESP;
            up_ack_vld_r <= 1'b1;
            up_err_r     <= 1'b1;
            up_rd_data_r <= {DATA_WIDTH{1'b0}};
            ds_addr_r    <= {(FORWARD_NUM*ADDR_WIDTH){1'b0}};
            ds_wr_en_r   <= {FORWARD_NUM{1'b0}};
            ds_rd_en_r   <= {FORWARD_NUM{1'b0}};
            ds_wr_data_r <= {(FORWARD_NUM*DATA_WIDTH){1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            stale_r      <= (stale_r & ~stale_clr_s) | onehot(sel_r);
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`else
          end else begin
            state_r <= ST_WAIT;
          end
`endif
        end

        ST_RESP: begin
          state_r      <= ST_IDLE;
          up_ack_vld_r <= 1'b0;
          up_err_r     <= 1'b0;
          up_rd_data_r <= {DATA_WIDTH{1'b0}};
        end

        default: begin
          state_r      <= ST_IDLE;
          up_ack_vld_r <= 1'b0;
          up_err_r     <= 1'b0;
          up_rd_data_r <= {DATA_WIDTH{1'b0}};
          ds_addr_r    <= {(FORWARD_NUM*ADDR_WIDTH){1'b0}};
          ds_wr_en_r   <= {FORWARD_NUM{1'b0}};
          ds_rd_en_r   <= {FORWARD_NUM{1'b0}};
          ds_wr_data_r <= {(FORWARD_NUM*DATA_WIDTH){1'b0}};
        end
      endcase
    end
  end

  assign up_ack_vld  = up_ack_vld_r;
  assign up_err      = up_err_r;
  assign up_rd_data  = up_rd_data_r;
  assign ds_req_vld  = ds_req_vld_r;
  assign ds_addr     = ds_addr_r;
  assign ds_wr_en    = ds_wr_en_r;
  assign ds_rd_en    = ds_rd_en_r;
  assign ds_wr_data  = ds_wr_data_r;
  assign ds_soft_rst = ds_soft_rst_r;

endmodule
